uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/parity_calc.sv | 31 +++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity-type constants,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/parity_calc.sv
// Parity generator shared by transmitter (generation) and receiver (checking).
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  function automatic logic xor_reduce(input logic [DATA_WIDTH-1:0] v);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      acc = acc ^ v[i];
    end
    return acc;
  endfunction

  // Even parity is the plain XOR; odd parity is its inverse.
  always_comb begin
    par_bit = 1'b0;
    case (par_typ)
      PAR_EVEN: par_bit = xor_reduce(data);
      PAR_ODD:  par_bit = ~xor_reduce(data);
      default:  par_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// each bit held for max(prescale,1) clocks. tx_out and busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE = PRESCALE_WIDTH'(1);

  uart_state_e               state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
  logic                      par_en_q, par_en_d;
  logic                      par_bit_q, par_bit_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      par_bit_s;
  logic                      bit_end_s;

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (p_data),
    .par_typ(par_typ),
    .par_bit(par_bit_s)
  );

  assign bit_end_s = (cnt_q == (presc_q - PS_ONE));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {PRESCALE_WIDTH{1'b0}};
      presc_q   <= PS_ONE;
      idx_q     <= {IDX_W{1'b0}};
      shreg_q   <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic; tx_d carries the value of the bit that starts next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d  = {PRESCALE_WIDTH{1'b0}};
        idx_d  = {IDX_W{1'b0}};
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
          state_d   = START;
          shreg_d   = p_data;
          par_en_d  = par_en;
          par_bit_d = par_bit_s;
          presc_d   = (prescale == {PRESCALE_WIDTH{1'b0}}) ? PS_ONE : prescale;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          cnt_d   = {PRESCALE_WIDTH{1'b0}};
          state_d = DATA;
          idx_d   = {IDX_W{1'b0}};
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          cnt_d = {PRESCALE_WIDTH{1'b0}};
          if (idx_q == IDX_LAST) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end

      PARITY: begin
        if (bit_end_s) begin
          cnt_d   = {PRESCALE_WIDTH{1'b0}};
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end

      STOP: begin
        if (bit_end_s) begin
          cnt_d   = {PRESCALE_WIDTH{1'b0}};
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + PS_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = {PRESCALE_WIDTH{1'b0}};
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frame shapes, parity, ignored
// requests, reset abort and back-to-back frames.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int cnt;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .prescale  (prescale),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one frame, then check tx_out/busy on every cycle of it and the idle
  // cycle after it. inj >= 0 pulses a 0x3C request (and new settings) mid-frame.
  task automatic frame(input string tag, input logic [7:0] d, input logic pe,
                       input logic pt, input logic [5:0] ps, input logic exp_par,
                       input bit keep, input int inj);
    logic [10:0] bits;
    int n, per, cyc;
    if (pe) begin
      bits = {1'b1, exp_par, d, 1'b0};
      n    = 11;
    end else begin
      bits = {2'b11, d, 1'b0};
      n    = 10;
    end
    per        = (ps == 6'd0) ? 1 : int'(ps);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    step();
    if (!keep) data_valid = 1'b0;
    cyc = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < per; c++) begin
        chk($sformatf("%s bit%0d cyc%0d tx", tag, b, c), 32'(tx_out), 32'(bits[b]));
        chk($sformatf("%s bit%0d cyc%0d busy", tag, b, c), 32'(busy), 32'd1);
        if (cyc == inj) begin
          data_valid = 1'b1;
          p_data     = 8'h3C;
          prescale   = 6'd3;
          par_en     = ~pe;
          par_typ    = ~pt;
        end else if (cyc == inj + 1) begin
          data_valid = 1'b0;
        end
        step();
        cyc++;
      end
    end
    chk($sformatf("%s idle tx", tag), 32'(tx_out), 32'd1);
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd1;
    step();
    step();
    chk("reset tx", 32'(tx_out), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    chk("post-reset idle tx", 32'(tx_out), 32'd1);

    // 0xA5, prescale 1, no parity: 0,1,0,1,0,0,1,0,1,1
    frame("a5_ps1", 8'hA5, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0, -1);

    // 0xA5, prescale 16, even parity -> parity bit 0
    frame("a5_ps16_even", 8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0, -1);

    // Same frame again, measuring the busy window length directly
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; prescale = 6'd16;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      step();
    end
    chk("busy_len_176", 32'(cnt), 32'd176);
    chk("busy_len idle tx", 32'(tx_out), 32'd1);

    // 0x01: odd parity -> 0, even parity -> 1
    frame("01_odd", 8'h01, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, -1);
    frame("01_even", 8'h01, 1'b1, 1'b0, 6'd3, 1'b1, 1'b0, -1);

    // 0xFF frame with a 0x3C request and setting changes during DATA
    frame("ff_inj", 8'hFF, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("no_3c tx%0d", i), 32'(tx_out), 32'd1);
      chk($sformatf("no_3c busy%0d", i), 32'(busy), 32'd0);
      step();
    end

    // Reset during the 4th data bit of a 0xF0 frame (prescale 2)
    p_data = 8'hF0; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd2;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("pre_abort d3 tx", 32'(tx_out), 32'd0);
    chk("pre_abort busy", 32'(busy), 32'd1);
    rst = 1'b1;
    data_valid = 1'b1;
    p_data = 8'h55;
    step();
    chk("abort tx", 32'(tx_out), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    step();
    chk("rst_hold tx", 32'(tx_out), 32'd1);
    chk("rst_hold busy", 32'(busy), 32'd0);
    rst = 1'b0;
    frame("55_after_rst", 8'h55, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0, -1);

    // Back-to-back frames with data_valid held high
    frame("b2b_1", 8'hC3, 1'b0, 1'b0, 6'd2, 1'b0, 1'b1, -1);
    frame("b2b_2", 8'h3A, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, -1);

    // prescale 0 behaves as prescale 1
    frame("a5_ps0", 8'hA5, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, -1);
    frame("81_ps0_par", 8'h81, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
